// File: rtl/clk_monitor_pkg.sv
// Shared types and helpers for the PLL clock monitor.
// State encoding, error counter width and the tolerance check.
package clk_monitor_pkg;

  typedef enum logic [1:0] {
    SYNC,
    MEASURE,
    LOST
  } mon_state_e;

  localparam int ERR_W = 8;

  // Lower bound clamps at zero; 32 bits keeps exp_v + tol from wrapping.
  function automatic logic in_window(
    input logic [31:0] val,
    input logic [31:0] exp_v,
    input logic [31:0] tol
  );
    logic [31:0] lo;
    lo = (exp_v >= tol) ? exp_v - tol : '0;
    return (val >= lo) && (val <= exp_v + tol);
  endfunction

endpackage

// File: rtl/ref_edge_sync.sv
// Two-flop synchroniser for the crystal reference plus a registered
// rising-edge pulse (three clk cycles from async_in rise to edge_pulse).
module ref_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], async_in};
      edge_pulse <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/clk_monitor.sv
// Qualifies the PLL clock against the crystal reference and sequences sys_rst.
// Define CLK_MONITOR_ERR_CNT_EN to build the saturating bad-window counter.
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int REF_PERIODS  = 16,
  parameter int EXP_COUNT    = 250,
  parameter int TOL          = 4,
  parameter int GOOD_WINDOWS = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ref_in,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             ref_lost,
  output logic             sys_rst,
  output logic [ERR_W-1:0] err_count
);

  localparam int EDGE_W = $clog2(REF_PERIODS + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int GR_W   = $clog2(GOOD_WINDOWS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mon_state_e        state_q;
  mon_state_e        state_d;
  logic              ref_edge;
  logic [CNT_W-1:0]  win_q;
  logic [EDGE_W-1:0] edge_q;
  logic [WD_W-1:0]   wd_q;
  logic [GR_W-1:0]   good_q;
  logic              meas_sat_q;
  logic              wd_expire;
  logic              win_close;
  logic              eval_good;

  ref_edge_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (ref_in),
    .edge_pulse(ref_edge)
  );

  // A coincident reference edge always beats watchdog expiry.
  assign wd_expire = !ref_edge && (state_q != LOST)
                   && (wd_q == WD_W'(TIMEOUT - 1));
  assign win_close = ref_edge && (state_q == MEASURE)
                   && (edge_q == EDGE_W'(REF_PERIODS - 1));
  assign eval_good = in_window(32'(meas_count), EXP_COUNT, TOL)
                   && !meas_sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC, LOST: if (ref_edge) state_d = MEASURE;
      MEASURE:    state_d = MEASURE;
      default:    state_d = SYNC;
    endcase
    if (wd_expire) state_d = LOST;
  end

  // Counters include the edge cycle itself, so a window spans edge to edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q      <= '0;
      edge_q     <= '0;
      wd_q       <= '0;
      meas_count <= '0;
      meas_sat_q <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= win_close;
      if (ref_edge)
        wd_q <= WD_W'(1);
      else if (wd_q != WD_W'(TIMEOUT - 1))
        wd_q <= wd_q + 1'b1;
      if (ref_edge && (state_q != MEASURE)) begin
        win_q  <= CNT_W'(1);
        edge_q <= '0;
      end else if (win_close) begin
        meas_count <= win_q;
        meas_sat_q <= (win_q == CNT_MAX);
        win_q      <= CNT_W'(1);
        edge_q     <= '0;
      end else if (state_q == MEASURE) begin
        if (win_q != CNT_MAX) win_q <= win_q + 1'b1;
        if (ref_edge)         edge_q <= edge_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_ok  <= 1'b0;
      ref_lost <= 1'b0;
      sys_rst  <= 1'b1;
      good_q   <= '0;
    end else begin
      if (wd_expire)     ref_lost <= 1'b1;
      else if (ref_edge) ref_lost <= 1'b0;
      if (wd_expire) begin
        freq_ok <= 1'b0;
        sys_rst <= 1'b1;
        good_q  <= '0;
      end else if (meas_valid) begin
        freq_ok <= eval_good;
        if (eval_good) begin
          if (good_q != GR_W'(GOOD_WINDOWS))
            good_q <= good_q + 1'b1;
          if (good_q >= GR_W'(GOOD_WINDOWS - 1))
            sys_rst <= 1'b0;
        end else begin
          good_q  <= '0;
          sys_rst <= 1'b1;
        end
      end
    end
  end

`ifdef CLK_MONITOR_ERR_CNT_EN
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= '0;
    else if ((wd_expire || (meas_valid && !eval_good))
             && (err_q != '1))
      err_q <= err_q + 1'b1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor: exact-length reference windows,
// a narrow-counter instance for saturation, loss and mid-window reset.
module tb_clk_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ref_in = 1'b0;
  logic [15:0] meas_count;
  logic        meas_valid, freq_ok, ref_lost, sys_rst;
  logic [7:0]  err_count;
  logic [7:0]  b_meas;
  logic        b_valid, b_ok, b_lost, b_rst;
  logic [7:0]  b_err;

  int total = 0;
  int bad = 0;
  int exp_err = 0;
  int valid_cnt = 0;
  int valid_dbl = 0;
  logic prev_valid = 1'b0;

  int nom_n[5] = '{250, 251, 250, 251, 250};
  int nom_c[5] = '{0, 250, 251, 250, 251};
  bit nom_o[5] = '{0, 1, 1, 1, 1};
  bit nom_r[5] = '{1, 1, 1, 1, 0};

  int gl_n[6] = '{277, 250, 251, 250, 250, 250};
  int gl_c[6] = '{250, 277, 250, 251, 250, 250};
  bit gl_o[6] = '{1, 0, 1, 1, 1, 1};
  bit gl_r[6] = '{0, 1, 1, 1, 1, 0};

  int bd_n[6] = '{246, 254, 245, 255, 250, 250};
  int bd_c[6] = '{250, 246, 254, 245, 255, 250};
  bit bd_o[6] = '{1, 1, 1, 0, 0, 1};
  bit bd_r[6] = '{0, 0, 0, 1, 1, 1};

  int of_n[3] = '{213, 213, 250};
  int of_c[3] = '{250, 213, 213};
  bit of_o[3] = '{1, 0, 0};
  bit of_r[3] = '{1, 1, 1};

  clk_monitor u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ref_in    (ref_in),
    .meas_count(meas_count),
    .meas_valid(meas_valid),
    .freq_ok   (freq_ok),
    .ref_lost  (ref_lost),
    .sys_rst   (sys_rst),
    .err_count (err_count)
  );

  clk_monitor #(.CNT_W(8), .TOL(8)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .ref_in    (ref_in),
    .meas_count(b_meas),
    .meas_valid(b_valid),
    .freq_ok   (b_ok),
    .ref_lost  (b_lost),
    .sys_rst   (b_rst),
    .err_count (b_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (meas_valid) valid_cnt++;
    if (meas_valid && prev_valid) valid_dbl++;
    prev_valid = meas_valid;
  end

  function automatic int err_exp();
`ifdef CLK_MONITOR_ERR_CNT_EN
    return exp_err;
`else
    return 0;
`endif
  endfunction

  // One reference period of n clk cycles, rising at its start.
  task automatic gap(input int n);
    ref_in = 1'b1;
    repeat (n / 2) @(negedge clk);
    ref_in = 1'b0;
    repeat (n - n / 2) @(negedge clk);
  endtask

  // Sixteen periods summing to exactly n clk cycles.
  task automatic win(input int n);
    for (int i = 0; i < 16; i++)
      gap(n / 16 + ((i < n % 16) ? 1 : 0));
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (meas_count !== 16'd0 || meas_valid !== 1'b0 ||
        freq_ok !== 1'b0 || ref_lost !== 1'b0 ||
        sys_rst !== 1'b1 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL reset cnt=%0d v=%b ok=%b lost=%b rst=%b err=%0d",
               meas_count, meas_valid, freq_ok, ref_lost, sys_rst,
               err_count);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_nominal();
    for (int i = 0; i < 5; i++) begin
      win(nom_n[i]);
      total++;
      if (meas_count !== 16'(nom_c[i]) || freq_ok !== nom_o[i] ||
          sys_rst !== nom_r[i]) begin
        bad++;
        $display("FAIL nominal[%0d] got=%0d/%b/%b want=%0d/%b/%b", i,
                 meas_count, freq_ok, sys_rst, nom_c[i], nom_o[i],
                 nom_r[i]);
      end
      total++;
      if (err_count !== 8'(err_exp()) || ref_lost !== 1'b0) begin
        bad++;
        $display("FAIL nominal_err[%0d] err=%0d lost=%b want=%0d/0",
                 i, err_count, ref_lost, err_exp());
      end
    end
    total++;
    if (valid_cnt !== 4 || valid_dbl !== 0) begin
      bad++;
      $display("FAIL valid_pulses got=%0d dbl=%0d want=4/0",
               valid_cnt, valid_dbl);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 6; i++) begin
      win(gl_n[i]);
      if (!gl_o[i]) exp_err++;
      total++;
      if (meas_count !== 16'(gl_c[i]) || freq_ok !== gl_o[i] ||
          sys_rst !== gl_r[i] || err_count !== 8'(err_exp())) begin
        bad++;
        $display("FAIL glitch[%0d] got=%0d/%b/%b/%0d want=%0d/%b/%b/%0d",
                 i, meas_count, freq_ok, sys_rst, err_count, gl_c[i],
                 gl_o[i], gl_r[i], err_exp());
      end
    end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 6; i++) begin
      win(bd_n[i]);
      if (!bd_o[i]) exp_err++;
      total++;
      if (meas_count !== 16'(bd_c[i]) || freq_ok !== bd_o[i] ||
          sys_rst !== bd_r[i] || err_count !== 8'(err_exp())) begin
        bad++;
        $display("FAIL boundary[%0d] got=%0d/%b/%b/%0d want=%0d/%b/%b/%0d",
                 i, meas_count, freq_ok, sys_rst, err_count, bd_c[i],
                 bd_o[i], bd_r[i], err_exp());
      end
    end
  endtask

  task automatic test_off_freq();
    for (int i = 0; i < 3; i++) begin
      win(of_n[i]);
      if (!of_o[i]) exp_err++;
      total++;
      if (meas_count !== 16'(of_c[i]) || freq_ok !== of_o[i] ||
          sys_rst !== of_r[i] || err_count !== 8'(err_exp())) begin
        bad++;
        $display("FAIL off_freq[%0d] got=%0d/%b/%b/%0d want=%0d/%b/%b/%0d",
                 i, meas_count, freq_ok, sys_rst, err_count, of_c[i],
                 of_o[i], of_r[i], err_exp());
      end
    end
  endtask

  task automatic test_saturation();
    win(300);
    total++;
    if (b_meas !== 8'd250 || b_ok !== 1'b1 || meas_count !== 16'd250 ||
        freq_ok !== 1'b1 || sys_rst !== 1'b1) begin
      bad++;
      $display("FAIL sat_pre got b=%0d/%b a=%0d/%b/%b want 250/1 250/1/1",
               b_meas, b_ok, meas_count, freq_ok, sys_rst);
    end
    win(250);
    exp_err++;
    total++;
    if (b_meas !== 8'd255 || b_ok !== 1'b0) begin
      bad++;
      $display("FAIL sat_narrow got=%0d/%b want=255/0", b_meas, b_ok);
    end
    total++;
    if (meas_count !== 16'd300 || freq_ok !== 1'b0 || sys_rst !== 1'b1 ||
        err_count !== 8'(err_exp())) begin
      bad++;
      $display("FAIL sat_wide got=%0d/%b/%b/%0d want=300/0/1/%0d",
               meas_count, freq_ok, sys_rst, err_count, err_exp());
    end
  endtask

  task automatic test_ref_loss();
    repeat (990) @(negedge clk);
    total++;
    if (ref_lost !== 1'b0) begin
      bad++;
      $display("FAIL loss_early got=%b want=0", ref_lost);
    end
    repeat (110) @(negedge clk);
    exp_err++;
    total++;
    if (ref_lost !== 1'b1 || freq_ok !== 1'b0 || sys_rst !== 1'b1 ||
        meas_count !== 16'd300 || err_count !== 8'(err_exp()) ||
        b_lost !== 1'b1) begin
      bad++;
      $display("FAIL loss got=%b/%b/%b/%0d/%0d/%b want=1/0/1/300/%0d/1",
               ref_lost, freq_ok, sys_rst, meas_count, err_count, b_lost,
               err_exp());
    end
    win(250);
    total++;
    if (ref_lost !== 1'b0 || meas_count !== 16'd300 ||
        freq_ok !== 1'b0 || sys_rst !== 1'b1) begin
      bad++;
      $display("FAIL loss_restart got=%b/%0d/%b/%b want=0/300/0/1",
               ref_lost, meas_count, freq_ok, sys_rst);
    end
    for (int i = 0; i < 4; i++) begin
      win(250);
      total++;
      if (meas_count !== 16'd250 || freq_ok !== 1'b1 ||
          sys_rst !== (i < 3)) begin
        bad++;
        $display("FAIL loss_recover[%0d] got=%0d/%b/%b want=250/1/%b",
                 i, meas_count, freq_ok, sys_rst, i < 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) gap(16);
    rst_n = 1'b0;
    exp_err = 0;
    #1;
    total++;
    if (meas_count !== 16'd0 || meas_valid !== 1'b0 ||
        freq_ok !== 1'b0 || ref_lost !== 1'b0 ||
        sys_rst !== 1'b1 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_mid cnt=%0d v=%b ok=%b lost=%b rst=%b err=%0d",
               meas_count, meas_valid, freq_ok, ref_lost, sys_rst,
               err_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    win(250);
    total++;
    if (meas_count !== 16'd0 || freq_ok !== 1'b0 || sys_rst !== 1'b1) begin
      bad++;
      $display("FAIL reset_first got=%0d/%b/%b want=0/0/1",
               meas_count, freq_ok, sys_rst);
    end
    for (int i = 0; i < 4; i++) begin
      win(250);
      total++;
      if (meas_count !== 16'd250 || sys_rst !== (i < 3) ||
          err_count !== 8'd0) begin
        bad++;
        $display("FAIL reset_recover[%0d] got=%0d/%b/%0d want=250/%b/0",
                 i, meas_count, sys_rst, err_count, i < 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_boundary();
    test_off_freq();
    test_saturation();
    test_ref_loss();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
